fetch: RTL

//  Stage 1 of the 5-stage RV32I pipeline. Owns the architectural PC and issues

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_pc_register.sv | 26 ++
 rtl/fetch.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the RV32I fetch stage: FSM encoding, reset PC and PC helpers.
package fetch_pkg;

  localparam logic [31:0] RV32I_RESET_PC = 32'h0000_0060;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    SQUASH = 2'd1,
    HOLD   = 2'd2
  } fetch_state_t;

  // Instruction fetch is word-granular; low address bits are simply dropped.
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_pc_register.sv
// Architectural request PC: 32-bit register with load enable and async reset to RESET_PC.
module pc_register
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RV32I_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic [31:0] i_d,
  output logic [31:0] o_q
);

  logic [31:0] r_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (i_load) begin
      r_pc <= i_d;
    end
  end

  assign o_q = r_pc;

endmodule

// File: rtl/fetch.sv
// IF stage: issues I-cache word reads for req_pc and delivers {pc, instr, valid} through
// a registered IF/ID boundary, with a one-entry skid buffer for stall and redirect squash.
module fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RV32I_RESET_PC
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         stall,
  input  logic         redirect,
  input  logic [31:0]  redirect_pc,
  output logic         imem_read,
  output logic [31:0]  imem_address,
  input  logic [31:0]  imem_rdata,
  input  logic         imem_resp,
  output logic [31:0]  pc_out,
  output logic [31:0]  instr_out,
  output logic         valid_out,
  output fetch_state_t dbg_state
);

  // Handshake: a read is outstanding while imem_read=1; imem_address must not change
  // until the single-cycle imem_resp pulse completes it. IF/ID holds while stall=1.

  fetch_state_t r_state, w_next;
  logic [31:0]  w_req_pc, w_pc_d, w_redirect_pc;
  logic         w_pc_load, w_tgt_load, w_skid_load;
  logic [31:0]  r_tgt, r_skid_pc, r_skid_instr;
  logic [31:0]  r_pc_out, r_instr_out;
  logic         r_valid_out;
  logic [31:0]  w_ifid_pc, w_ifid_instr;
  logic         w_ifid_valid;

  pc_register #(.RESET_PC(RESET_PC)) u_pc (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_pc_load),
    .i_d    (w_pc_d),
    .o_q    (w_req_pc)
  );

  assign w_redirect_pc = word_align(redirect_pc);
  assign imem_address  = w_req_pc;
  assign imem_read     = rst_n & (r_state != HOLD);
  assign pc_out        = r_pc_out;
  assign instr_out     = r_instr_out;
  assign valid_out     = r_valid_out;
  assign dbg_state     = r_state;

  always_comb begin
    w_next       = r_state;
    w_pc_load    = 1'b0;
    w_pc_d       = w_req_pc;
    w_tgt_load   = 1'b0;
    w_skid_load  = 1'b0;
    w_ifid_pc    = r_pc_out;
    w_ifid_instr = r_instr_out;
    w_ifid_valid = r_valid_out;
    case (r_state)
      FETCH: begin
        if (redirect) begin
          w_ifid_valid = 1'b0;
          if (imem_resp) begin
            w_pc_load = 1'b1;
            w_pc_d    = w_redirect_pc;
          end else begin
            // Address must stay put until the stale read completes.
            w_tgt_load = 1'b1;
            w_next     = SQUASH;
          end
        end else if (imem_resp) begin
          if (stall) begin
            w_skid_load = 1'b1;
            w_next      = HOLD;
          end else begin
            w_ifid_pc    = w_req_pc;
            w_ifid_instr = imem_rdata;
            w_ifid_valid = 1'b1;
            w_pc_load    = 1'b1;
            w_pc_d       = w_req_pc + 32'd4;
          end
        end else if (!stall) begin
          w_ifid_valid = 1'b0;
        end
      end
      SQUASH: begin
        if (redirect || !stall) begin
          w_ifid_valid = 1'b0;
        end
        w_tgt_load = redirect;
        if (imem_resp) begin
          w_pc_load = 1'b1;
          w_pc_d    = redirect ? w_redirect_pc : r_tgt;
          w_next    = FETCH;
        end
      end
      HOLD: begin
        if (redirect) begin
          w_ifid_valid = 1'b0;
          w_pc_load    = 1'b1;
          w_pc_d       = w_redirect_pc;
          w_next       = FETCH;
        end else if (!stall) begin
          w_ifid_pc    = r_skid_pc;
          w_ifid_instr = r_skid_instr;
          w_ifid_valid = 1'b1;
          w_pc_load    = 1'b1;
          w_pc_d       = r_skid_pc + 32'd4;
          w_next       = FETCH;
        end
      end
      default: w_next = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= FETCH;
      r_tgt        <= '0;
      r_skid_pc    <= '0;
      r_skid_instr <= '0;
      r_pc_out     <= '0;
      r_instr_out  <= '0;
      r_valid_out  <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_pc_out    <= w_ifid_pc;
      r_instr_out <= w_ifid_instr;
      r_valid_out <= w_ifid_valid;
      if (w_tgt_load) begin
        r_tgt <= w_redirect_pc;
      end
      if (w_skid_load) begin
        r_skid_pc    <= w_req_pc;
        r_skid_instr <= imem_rdata;
      end
    end
  end

endmodule
